// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - serial double-dabble BCD converter driving a 3-digit multiplexed 7-seg display
//
// Converts an 8-bit binary value to three BCD digits (one bit per clock) and
// scans the latched result onto a common-anode, active-low 7-segment display.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-low reset
//   value_in  8-bit binary value, captured on start while idle
//   start     single-cycle conversion request (ignored while busy)
//   blank_en  1 = blank leading zeros on hundreds/tens
//   busy      high while a conversion is shifting
//   bcd_out   latched result {hundreds, tens, ones}
//   seg_7     active-low segments {a,b,c,d,e,f,g}
//   an        active-low digit enables: [0] ones, [1] tens, [2] hundreds
`timescale 1ns/1ps
module bcd_scan_display #(
  parameter int SCAN_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value_in,
  input  logic        start,
  input  logic        blank_en,
  output logic        busy,
  output logic [11:0] bcd_out,
  output logic [6:0]  seg_7,
  output logic [2:0]  an
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  shift_q, shift_nxt;
  logic [11:0] work_q, work_nxt, work_adj;
  logic [2:0]  step_q, step_nxt;
  logic [11:0] bcd_nxt;

  // Add-3 correction applied before every shift keeps each nibble a valid
  // decimal digit after doubling.
  always_comb begin
    work_adj = work_q;
    for (int n = 0; n < 3; n++) begin
      if (work_q[n*4 +: 4] >= 4'd5)
        work_adj[n*4 +: 4] = work_q[n*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    work_nxt  = work_q;
    step_nxt  = step_q;
    bcd_nxt   = bcd_out;
    case (state)
      IDLE: begin
        if (start) begin
          shift_nxt = value_in;
          work_nxt  = 12'd0;
          step_nxt  = 3'd0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        {work_nxt, shift_nxt} = {work_adj, shift_q} << 1;
        step_nxt = step_q + 3'd1;
        // Eighth shift: the shifted work value is the finished result.
        if (step_q == 3'd7) begin
          bcd_nxt   = work_nxt;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shift_q <= 8'd0;
      work_q  <= 12'd0;
      step_q  <= 3'd0;
      bcd_out <= 12'd0;
    end else begin
      state   <= state_nxt;
      shift_q <= shift_nxt;
      work_q  <= work_nxt;
      step_q  <= step_nxt;
      bcd_out <= bcd_nxt;
    end
  end

  assign busy = (state == SHIFT);

  // Display scan
  logic [SCAN_DIV-1:0] refresh_q;
  logic [1:0]          digit_idx;
  logic                scan_tick;
  logic [3:0]          nibble;
  logic                blank;
  logic [6:0]          seg_nxt;
  logic [2:0]          an_nxt;

  assign scan_tick = &refresh_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
      digit_idx <= 2'd0;
    end else begin
      refresh_q <= refresh_q + {{(SCAN_DIV-1){1'b0}}, 1'b1};
      if (scan_tick)
        digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
    end
  end

  always_comb begin
    nibble = bcd_out[3:0];
    an_nxt = 3'b110;
    blank  = 1'b0;
    case (digit_idx)
      2'd0: begin
        nibble = bcd_out[3:0];
        an_nxt = 3'b110;
      end
      2'd1: begin
        nibble = bcd_out[7:4];
        an_nxt = 3'b101;
        blank  = blank_en && (bcd_out[11:8] == 4'd0) && (bcd_out[7:4] == 4'd0);
      end
      default: begin
        nibble = bcd_out[11:8];
        an_nxt = 3'b011;
        blank  = blank_en && (bcd_out[11:8] == 4'd0);
      end
    endcase
  end

  always_comb begin
    seg_nxt = 7'b1111111;
    case (nibble)
      4'd0: seg_nxt = 7'b0000001;
      4'd1: seg_nxt = 7'b1001111;
      4'd2: seg_nxt = 7'b0010010;
      4'd3: seg_nxt = 7'b0000110;
      4'd4: seg_nxt = 7'b1001100;
      4'd5: seg_nxt = 7'b0100100;
      4'd6: seg_nxt = 7'b0100000;
      4'd7: seg_nxt = 7'b0001111;
      4'd8: seg_nxt = 7'b0000000;
      4'd9: seg_nxt = 7'b0001100;
      default: seg_nxt = 7'b1111111;
    endcase
    if (blank)
      seg_nxt = 7'b1111111;
  end

  // an and seg_7 register together so the digit enable and its segments
  // always switch on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an    <= 3'b110;
      seg_7 <= 7'b0000001;
    end else begin
      an    <= an_nxt;
      seg_7 <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - directed self-checking bench for bcd_scan_display
`timescale 1ns/1ps
module tb_bcd_scan_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  value_in;
  logic        start;
  logic        blank_en;
  logic        busy;
  logic [11:0] bcd_out;
  logic [6:0]  seg_7;
  logic [2:0]  an;

  int checks = 0;
  int errors = 0;

  bcd_scan_display #(.SCAN_DIV(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .value_in (value_in),
    .start    (start),
    .blank_en (blank_en),
    .busy     (busy),
    .bcd_out  (bcd_out),
    .seg_7    (seg_7),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Start at edge k, check busy after k..k+7, then result and busy low at k+8.
  task automatic convert(input int v);
    value_in = 8'(v);
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("busy_high", {11'd0, busy}, 12'd1);
      tick();
    end
    chk("busy_low", {11'd0, busy}, 12'd0);
    chk("bcd_result", bcd_out, to_bcd(v));
  endtask

  // Sample one full frame (12 clocks at SCAN_DIV=2) and check each digit.
  task automatic capture_frame(input string tag, input logic [6:0] eh,
                               input logic [6:0] et, input logic [6:0] eo);
    int n0 = 0, n1 = 0, n2 = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      case (an)
        3'b110: begin chk({tag, "_ones"}, {5'd0, seg_7}, {5'd0, eo}); n0++; end
        3'b101: begin chk({tag, "_tens"}, {5'd0, seg_7}, {5'd0, et}); n1++; end
        3'b011: begin chk({tag, "_hund"}, {5'd0, seg_7}, {5'd0, eh}); n2++; end
        default: chk({tag, "_an_valid"}, {9'd0, an}, 12'h006);
      endcase
    end
    chk({tag, "_dwell_ones"}, 12'(n0), 12'd4);
    chk({tag, "_dwell_tens"}, 12'(n1), 12'd4);
    chk({tag, "_dwell_hund"}, 12'(n2), 12'd4);
  endtask

  initial begin
    logic [2:0] prev_an;
    logic [2:0] exp_next;

    reset    = 1'b0;
    start    = 1'b0;
    value_in = 8'd0;
    blank_en = 1'b0;
    #12;
    chk("rst_busy", {11'd0, busy}, 12'd0);
    chk("rst_bcd",  bcd_out, 12'h000);
    chk("rst_an",   {9'd0, an}, 12'h006);
    chk("rst_seg",  {5'd0, seg_7}, 12'h001);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // 255 and its scan pattern
    convert(255);
    capture_frame("f255", 7'b0010010, 7'b0100100, 7'b0100100);

    // Every input value with 9-cycle spacing
    for (int v = 0; v < 256; v++) convert(v);

    // Leading-zero blanking
    blank_en = 1'b1;
    convert(7);
    capture_frame("blank7", 7'b1111111, 7'b1111111, 7'b0001111);
    convert(100);
    capture_frame("blank100", 7'b1001111, 7'b0000001, 7'b0000001);
    blank_en = 1'b0;
    convert(7);
    capture_frame("noblank7", 7'b0000001, 7'b0000001, 7'b0001111);

    // Starts during SHIFT are ignored, including the one at k+8
    value_in = 8'd42;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      if (e == 3 || e == 8) begin
        value_in = 8'd99;
        start    = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk("ign_busy", {11'd0, busy}, 12'd0);
    chk("ign_bcd", bcd_out, 12'h042);
    value_in = 8'd99;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 0; e < 7; e++) tick();
    chk("k16_bcd", bcd_out, 12'h042);
    tick();
    chk("k17_bcd", bcd_out, 12'h099);

    // Ten frames: an is always one valid digit and advances in order
    prev_an = an;
    for (int i = 0; i < 120; i++) begin
      tick();
      chk("an_valid", {11'd0, (an == 3'b110 || an == 3'b101 || an == 3'b011)}, 12'd1);
      if (an != prev_an) begin
        exp_next = (prev_an == 3'b110) ? 3'b101 : (prev_an == 3'b101) ? 3'b011 : 3'b110;
        chk("an_order", {9'd0, an}, {9'd0, exp_next});
      end
      prev_an = an;
    end

    // Reset in the middle of converting 200
    value_in = 8'd200;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 0; e < 4; e++) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {11'd0, busy}, 12'd0);
    chk("arst_bcd", bcd_out, 12'h000);
    chk("arst_an", {9'd0, an}, 12'h006);
    chk("arst_seg", {5'd0, seg_7}, 12'h001);
    tick();
    chk("arst_hold_busy", {11'd0, busy}, 12'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      chk("rescan_idx0", {9'd0, an}, 12'h006);
    end
    tick();
    chk("rescan_idx1", {9'd0, an}, 12'h005);
    for (int e = 0; e < 10; e++) tick();
    chk("no_partial_bcd", bcd_out, 12'h000);
    chk("no_partial_busy", {11'd0, busy}, 12'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Sequential display back-end that consumes the 8-bit correlation result and shows it on a three-digit multiplexed common-anode 7-segment display. It uses shift-and-add-3 (double dabble) to convert the binary value to BCD, one bit per clock. It then holds the BCD result in a display register and time-multiplexes the three digits using a free-running refresh counter. It sits directly downstream of the correlator and replaces its single-digit decoder.

## Interface

Parameters:
- SCAN_DIV, 16: refresh counter width. One digit advance per 2^SCAN_DIV clocks. Minimum 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- value_in  input  8  binary value to convert
- start  input  1  single-cycle request. Captures value_in when idle.
- blank_en  input  1  1 = blank leading zeros
- busy  output  1  conversion in progress
- bcd_out  output  12  latched result: [11:8] hundreds, [7:4] tens, [3:0] ones
- seg_7  output  7  active-low segments {a,b,c,d,e,f,g}
- an  output  3  active-low digit enables: [0] ones, [1] tens, [2] hundreds

## Operation

Conversion FSM:
- States are IDLE and SHIFT.
- IDLE with start=1: load shift register = value_in, clear the 12-bit BCD work register, set step count = 0, go to SHIFT.
- IDLE with start=0: no change.
- SHIFT, each clock:
  - Add 3 to every work nibble that is ≥5.
  - Shift {work, shift} left by 1.
  - Increment the step count.
- SHIFT with step count = 7: write the final shifted work value to bcd_out and go to IDLE.
- start is ignored in SHIFT. No queuing.
- busy = 1 exactly while in SHIFT.
- Width rule: maximum input 255 gives at most 2/5/5, so nibbles never exceed 9.

Display:
- Refresh counter: SCAN_DIV bits, free-running.
- Scan tick: the cycle in which the counter is all-ones.
- Digit index: cycles 0→1→2→0 on each scan tick. It never takes the value 3.
- an is registered from the digit index:
  - index 0 → 3'b110
  - index 1 → 3'b101
  - index 2 → 3'b011
- seg_7 is registered from the selected bcd_out nibble:
  - 0 → 0000001
  - 1 → 1001111
  - 2 → 0010010
  - 3 → 0000110
  - 4 → 1001100
  - 5 → 0100100
  - 6 → 0100000
  - 7 → 0001111
  - 8 → 0000000
  - 9 → 0001100
  - Any other nibble → 1111111.
- Blanking (seg_7 = 1111111) applies only when blank_en = 1:
  - Hundreds digit is blanked when hundreds = 0.
  - Tens digit is blanked when hundreds = 0 and tens = 0.
  - Ones digit is never blanked.
- The display always shows bcd_out. A conversion in progress does not disturb it.

## Timing

- Reset (reset = 0, asynchronous) drives:
  - FSM to IDLE, busy = 0, bcd_out = 0.
  - Shift, work and step registers to 0.
  - Refresh counter = 0, digit index = 0.
  - an = 3'b110, seg_7 = 0000001 (a "0" on the ones digit).
- Reset asserted mid-conversion aborts the conversion. The result is lost, bcd_out = 0, and no partial value is ever written.
- Conversion latency:
  - start sampled at edge k.
  - busy rises after edge k.
  - Shifts occur on edges k+1 … k+8.
  - bcd_out is updated and busy falls at edge k+8.
  - busy is high for exactly 8 cycles.
- The earliest next accepted start is sampled at edge k+9. A start at edge k+8 is ignored because the FSM is still in SHIFT.
- Back-to-back conversions give one result per 9 cycles.
- Display pipeline:
  - an and seg_7 follow a digit-index change or a bcd_out change by one clock.
  - an and seg_7 always change on the same edge, so no cross-digit ghosting occurs.
- Dwell per digit is 2^SCAN_DIV clocks. The full frame is 3·2^SCAN_DIV clocks.
- A blank_en change takes effect on seg_7 one clock later.

## Test plan

- Reset, then value_in = 255 with a start pulse (SCAN_DIV = 2):
  - busy is high for 8 cycles.
  - bcd_out = 12'h255 at edge k+8.
  - Scan shows an = 110 / seg 0100100, then 101 / 0100100, then 011 / 0010010, each for 4 clocks.
- Exhaustive check: start for each value 0…255 with 9-cycle spacing. After each conversion, bcd_out must equal the decimal digits of value_in.
- blank_en = 1 with value 7: hundreds and tens show 1111111 and ones shows 0001111. With value 100: digits show 1, 0, 0 and the tens 0 is not blanked.
- Start at 42, then pulse start with value 99 during cycles k+3 and k+8:
  - Both pulses are ignored and bcd_out = 12'h042.
  - A start with 99 at k+9 gives 12'h099 at k+17.
- Convert 200, then assert reset at k+4:
  - busy = 0 immediately and bcd_out = 0.
  - an = 110 and seg_7 = 0000001 asynchronously.
  - After release, scanning restarts from index 0.
- Digit index never reaches 3 over 10 frames: an is never 111 or 100, and at most one an bit is 0 at any time.
